// File: rtl/axi_sram_slave_pkg.sv
// Shared definitions for the AXI SRAM slave: response codes and the
// read/write channel FSM state encodings.
package axi_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    // A DECERR beat outranks a Wlast framing error.
    function automatic logic [1:0] resp_sel(input logic dec, input logic slv);
        logic [1:0] resp;
        if (dec) begin
            resp = RESP_DECERR;
        end else if (slv) begin
            resp = RESP_SLVERR;
        end else begin
            resp = RESP_OKAY;
        end
        return resp;
    endfunction

endpackage

// File: rtl/axi_sram_array.sv
// Word-organised SRAM with a byte-enabled write port and a registered read
// port; the read register can be forced to zero for decode-error beats.
module axi_sram_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_r [0:(1<<AW)-1];
    logic [31:0] rd_data_r;

    // Byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_strb[b]) begin
                mem_r[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Read register samples the old word when a write hits the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 32'd0;
        end else if (rd_clr) begin
            rd_data_r <= 32'd0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-style INCR burst slave in front of a single-port-per-direction SRAM,
// with independent read and write channel FSMs.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic        Clk,
    input  logic        Rest,
    input  logic [3:0]  Arid,
    input  logic [31:0] Araddr,
    input  logic [7:0]  Arlen,
    input  logic        Arvalid,
    output logic        Arready,
    output logic [3:0]  Rid,
    output logic [31:0] Rdata,
    output logic [1:0]  Rresp,
    output logic        Rlast,
    output logic        Rvalid,
    input  logic        Rready,
    input  logic [3:0]  Awid,
    input  logic [31:0] Awaddr,
    input  logic [7:0]  Awlen,
    input  logic        Awvalid,
    output logic        Awready,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    input  logic        Wlast,
    input  logic        Wvalid,
    output logic        Wready,
    output logic [3:0]  Bid,
    output logic [1:0]  Bresp,
    output logic        Bvalid,
    input  logic        Bready
);

    function automatic logic word_oor(input logic [29:0] word);
        return |(word >> MEM_AW);
    endfunction

    r_state_e    r_state_r, r_state_s;
    logic [3:0]  rid_r, rid_s;
    logic [29:0] raddr_r, raddr_s;
    logic [7:0]  rcnt_r, rcnt_s;
    logic [1:0]  rresp_r, rresp_s;
    logic        rlast_r, rlast_s;
    logic        fetch_s;
    logic [29:0] fetch_word_s;
    logic        rd_en_s, rd_clr_s;
    logic [31:0] rdata_s;

    w_state_e    w_state_r, w_state_s;
    logic [3:0]  bid_r, bid_s;
    logic [29:0] waddr_r, waddr_s;
    logic [7:0]  wcnt_r, wcnt_s;
    logic        wdec_r, wdec_s;
    logic        wslv_r, wslv_s;
    logic [1:0]  bresp_r, bresp_s;
    logic        wr_en_s;

    logic        unused_s;
    assign unused_s = ^{Araddr[1:0], Awaddr[1:0]};

    // Read channel: each accepted beat (or the AR handshake) fetches the next word.
    always_comb begin
        r_state_s    = r_state_r;
        rid_s        = rid_r;
        raddr_s      = raddr_r;
        rcnt_s       = rcnt_r;
        rlast_s      = rlast_r;
        fetch_s      = 1'b0;
        fetch_word_s = raddr_r;
        case (r_state_r)
            R_IDLE: begin
                if (Arvalid) begin
                    r_state_s    = R_DATA;
                    rid_s        = Arid;
                    raddr_s      = Araddr[31:2];
                    rcnt_s       = Arlen;
                    rlast_s      = (Arlen == 8'd0);
                    fetch_s      = 1'b1;
                    fetch_word_s = Araddr[31:2];
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (Rready && rlast_r) begin
                    r_state_s = R_IDLE;
                    rlast_s   = 1'b0;
                end else if (Rready) begin
                    raddr_s      = raddr_r + 30'd1;
                    rcnt_s       = rcnt_r - 8'd1;
                    rlast_s      = (rcnt_r == 8'd1);
                    fetch_s      = 1'b1;
                    fetch_word_s = raddr_r + 30'd1;
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: begin
                r_state_s = R_IDLE;
            end
        endcase
        if (fetch_s) begin
            rresp_s = word_oor(fetch_word_s) ? RESP_DECERR : RESP_OKAY;
        end else begin
            rresp_s = rresp_r;
        end
    end

    assign rd_en_s  = fetch_s & ~word_oor(fetch_word_s);
    assign rd_clr_s = fetch_s & word_oor(fetch_word_s);

    // Read channel state register.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_state_r <= R_IDLE;
            rid_r     <= 4'd0;
            raddr_r   <= 30'd0;
            rcnt_r    <= 8'd0;
            rresp_r   <= RESP_OKAY;
            rlast_r   <= 1'b0;
        end else begin
            r_state_r <= r_state_s;
            rid_r     <= rid_s;
            raddr_r   <= raddr_s;
            rcnt_r    <= rcnt_s;
            rresp_r   <= rresp_s;
            rlast_r   <= rlast_s;
        end
    end

    // Write channel: length comes from Awlen; Wlast is only checked, never obeyed.
    always_comb begin
        w_state_s = w_state_r;
        bid_s     = bid_r;
        waddr_s   = waddr_r;
        wcnt_s    = wcnt_r;
        wdec_s    = wdec_r;
        wslv_s    = wslv_r;
        bresp_s   = bresp_r;
        wr_en_s   = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (Awvalid) begin
                    w_state_s = W_DATA;
                    bid_s     = Awid;
                    waddr_s   = Awaddr[31:2];
                    wcnt_s    = Awlen;
                    wdec_s    = 1'b0;
                    wslv_s    = 1'b0;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_DATA: begin
                if (Wvalid) begin
                    wr_en_s = ~word_oor(waddr_r);
                    wdec_s  = wdec_r | word_oor(waddr_r);
                    wslv_s  = wslv_r | (Wlast != (wcnt_r == 8'd0));
                    if (wcnt_r == 8'd0) begin
                        w_state_s = W_RESP;
                        bresp_s   = resp_sel(wdec_s, wslv_s);
                    end else begin
                        waddr_s = waddr_r + 30'd1;
                        wcnt_s  = wcnt_r - 8'd1;
                    end
                end else begin
                    w_state_s = W_DATA;
                end
            end
            W_RESP: begin
                if (Bready) begin
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: begin
                w_state_s = W_IDLE;
            end
        endcase
    end

    // Write channel state register.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            w_state_r <= W_IDLE;
            bid_r     <= 4'd0;
            waddr_r   <= 30'd0;
            wcnt_r    <= 8'd0;
            wdec_r    <= 1'b0;
            wslv_r    <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_state_s;
            bid_r     <= bid_s;
            waddr_r   <= waddr_s;
            wcnt_r    <= wcnt_s;
            wdec_r    <= wdec_s;
            wslv_r    <= wslv_s;
            bresp_r   <= bresp_s;
        end
    end

    axi_sram_array #(
        .AW(MEM_AW)
    ) u_array (
        .clk     (Clk),
        .rst_n   (Rest),
        .wr_en   (wr_en_s),
        .wr_addr (waddr_r[MEM_AW-1:0]),
        .wr_data (Wdata),
        .wr_strb (Wstrb),
        .rd_en   (rd_en_s),
        .rd_clr  (rd_clr_s),
        .rd_addr (fetch_word_s[MEM_AW-1:0]),
        .rd_data (rdata_s)
    );

    assign Arready = (r_state_r == R_IDLE);
    assign Rvalid  = (r_state_r == R_DATA);
    assign Rid     = rid_r;
    assign Rdata   = rdata_s;
    assign Rresp   = rresp_r;
    assign Rlast   = rlast_r;
    assign Awready = (w_state_r == W_IDLE);
    assign Wready  = (w_state_r == W_DATA);
    assign Bvalid  = (w_state_r == W_RESP);
    assign Bid     = bid_r;
    assign Bresp   = bresp_r;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised bench for axi_sram_slave against a word-array reference model
// that applies the burst, strobe, range and response rules directly.
module tb_axi_sram_slave;

    localparam int MEM_AW = 12;
    localparam int NWORDS = 1 << MEM_AW;
    localparam int TMO    = 200;

    logic        Clk = 1'b0;
    logic        Rest;
    logic [3:0]  Arid;
    logic [31:0] Araddr;
    logic [7:0]  Arlen;
    logic        Arvalid;
    logic        Arready;
    logic [3:0]  Rid;
    logic [31:0] Rdata;
    logic [1:0]  Rresp;
    logic        Rlast;
    logic        Rvalid;
    logic        Rready;
    logic [3:0]  Awid;
    logic [31:0] Awaddr;
    logic [7:0]  Awlen;
    logic        Awvalid;
    logic        Awready;
    logic [31:0] Wdata;
    logic [3:0]  Wstrb;
    logic        Wlast;
    logic        Wvalid;
    logic        Wready;
    logic [3:0]  Bid;
    logic [1:0]  Bresp;
    logic        Bvalid;
    logic        Bready;

    axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
        .Clk(Clk), .Rest(Rest),
        .Arid(Arid), .Araddr(Araddr), .Arlen(Arlen), .Arvalid(Arvalid), .Arready(Arready),
        .Rid(Rid), .Rdata(Rdata), .Rresp(Rresp), .Rlast(Rlast), .Rvalid(Rvalid), .Rready(Rready),
        .Awid(Awid), .Awaddr(Awaddr), .Awlen(Awlen), .Awvalid(Awvalid), .Awready(Awready),
        .Wdata(Wdata), .Wstrb(Wstrb), .Wlast(Wlast), .Wvalid(Wvalid), .Wready(Wready),
        .Bid(Bid), .Bresp(Bresp), .Bvalid(Bvalid), .Bready(Bready)
    );

    always #5 Clk = ~Clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem_m [0:NWORDS-1];
    logic [31:0] wd_a  [0:15];
    logic [3:0]  ws_a  [0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >> (MEM_AW + 2)) == 32'd0;
    endfunction

    task automatic check_reset_outputs();
        chk("rst_arready", 32'(Arready), 32'd1);
        chk("rst_awready", 32'(Awready), 32'd1);
        chk("rst_rvalid",  32'(Rvalid),  32'd0);
        chk("rst_rlast",   32'(Rlast),   32'd0);
        chk("rst_wready",  32'(Wready),  32'd0);
        chk("rst_bvalid",  32'(Bvalid),  32'd0);
        chk("rst_rid",     32'(Rid),     32'd0);
        chk("rst_bid",     32'(Bid),     32'd0);
        chk("rst_rdata",   Rdata,        32'd0);
        chk("rst_rresp",   32'(Rresp),   32'd0);
        chk("rst_bresp",   32'(Bresp),   32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge Clk);
        Rest = 1'b0; Arvalid = 1'b0; Awvalid = 1'b0; Wvalid = 1'b0;
        Wlast = 1'b0; Rready = 1'b0; Bready = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge Clk);
        Rest = 1'b1;
    endtask

    task automatic aw_handshake(input logic [3:0] id, input logic [31:0] addr, input int len);
        int t = 0;
        @(negedge Clk);
        Awid = id; Awaddr = addr; Awlen = 8'(len); Awvalid = 1'b1;
        while (!Awready && t < TMO) begin @(negedge Clk); t++; end
        chk("aw_wait", 32'(t < TMO), 32'd1);
        @(negedge Clk);
        Awvalid = 1'b0;
    endtask

    // Sends beat i of wd_a/ws_a and applies it to the model.
    task automatic w_beat(input logic [31:0] addr, input int i, input int wlast_idx, inout bit dec);
        int t = 0;
        logic [31:0] a;
        a = addr + 32'(4 * i);
        Wvalid = 1'b1; Wdata = wd_a[i]; Wstrb = ws_a[i]; Wlast = (i == wlast_idx);
        while (!Wready && t < TMO) begin @(negedge Clk); t++; end
        chk("w_wait", 32'(t < TMO), 32'd1);
        @(negedge Clk);
        Wvalid = 1'b0; Wlast = 1'b0;
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (ws_a[i][b]) mem_m[a[MEM_AW+1:2]][8*b +: 8] = wd_a[i][8*b +: 8];
            end
        end else begin
            dec = 1'b1;
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len, input int wlast_idx);
        bit dec = 1'b0;
        bit slv = 1'b0;
        int t = 0;
        logic [1:0] exp_resp;
        aw_handshake(id, addr, len);
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge Clk);
            w_beat(addr, i, wlast_idx, dec);
            if ((i == wlast_idx) != (i == len)) slv = 1'b1;
        end
        exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
        repeat ($urandom_range(0, 2)) @(negedge Clk);
        while (!Bvalid && t < TMO) begin @(negedge Clk); t++; end
        chk("b_wait", 32'(t < TMO), 32'd1);
        Bready = 1'b1;
        chk("bid", 32'(Bid), 32'(id));
        chk("bresp", 32'(Bresp), 32'(exp_resp));
        @(negedge Clk);
        Bready = 1'b0;
        chk("bvalid_drop", 32'(Bvalid), 32'd0);
    endtask

    // mode 0: Rready always high, 1: toggling, 2: random.
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int mode);
        int beat = 0;
        int t = 0;
        int cyc = 0;
        bit done = 1'b0;
        logic [31:0] a;
        logic [31:0] ed;
        logic [1:0]  er;
        @(negedge Clk);
        Arid = id; Araddr = addr; Arlen = 8'(len); Arvalid = 1'b1; Rready = 1'b0;
        while (!Arready && t < TMO) begin @(negedge Clk); t++; end
        chk("ar_wait", 32'(t < TMO), 32'd1);
        @(negedge Clk);
        Arvalid = 1'b0;
        chk("rvalid_first", 32'(Rvalid), 32'd1);
        t = 0;
        while (!done && t < TMO) begin
            if (mode == 0)      Rready = 1'b1;
            else if (mode == 1) Rready = cyc[0];
            else                Rready = 1'($urandom_range(0, 1));
            a  = addr + 32'(4 * beat);
            ed = in_range(a) ? mem_m[a[MEM_AW+1:2]] : 32'd0;
            er = in_range(a) ? 2'b00 : 2'b11;
            chk("rvalid", 32'(Rvalid), 32'd1);
            chk("rid", 32'(Rid), 32'(id));
            chk("rdata", Rdata, ed);
            chk("rresp", 32'(Rresp), 32'(er));
            chk("rlast", 32'(Rlast), 32'(beat == len));
            if (Rvalid && Rready) begin
                if (beat == len) done = 1'b1;
                else beat++;
            end
            @(negedge Clk);
            cyc++; t++;
        end
        Rready = 1'b0;
        chk("r_done", 32'(done), 32'd1);
        chk("rvalid_after", 32'(Rvalid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int word;
        int wl;
        bit dec;
        logic [31:0] addr;
        Rest = 1'b0; Arid = 4'd0; Araddr = 32'd0; Arlen = 8'd0; Arvalid = 1'b0; Rready = 1'b0;
        Awid = 4'd0; Awaddr = 32'd0; Awlen = 8'd0; Awvalid = 1'b0; Wdata = 32'd0;
        Wstrb = 4'd0; Wlast = 1'b0; Wvalid = 1'b0; Bready = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_outputs();
        Rest = 1'b1;

        // Fill words 0..127 so every later read has a known model value.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 8; i++) begin wd_a[i] = $urandom; ws_a[i] = 4'hF; end
            axi_write(4'(k), 32'(32 * k), 7, 7);
        end

        for (int i = 0; i < 4; i++) begin wd_a[i] = 32'(i + 1); ws_a[i] = 4'hF; end
        axi_write(4'd5, 32'h40, 3, 3);
        axi_read(4'd9, 32'h40, 3, 0);

        wd_a[0] = 32'hAABBCCDD; ws_a[0] = 4'hF;
        axi_write(4'd1, 32'h100, 0, 0);
        wd_a[0] = 32'h11223344; ws_a[0] = 4'h5;
        axi_write(4'd2, 32'h100, 0, 0);
        axi_read(4'd3, 32'h100, 0, 0);
        chk("merge_word", mem_m[64], 32'hAA22CC44);

        axi_read(4'd6, 32'h0, 7, 1);

        axi_read(4'd7, 32'h4000, 3, 2);
        for (int i = 0; i < 2; i++) begin wd_a[i] = $urandom; ws_a[i] = 4'hF; end
        axi_write(4'd8, 32'h4000, 1, 1);
        axi_read(4'd8, 32'h0, 1, 0);
        axi_write(4'd4, 32'h3FFC, 1, 1);
        axi_read(4'd4, 32'h3FFC, 2, 0);

        for (int i = 0; i < 2; i++) begin wd_a[i] = $urandom; ws_a[i] = 4'hF; end
        axi_write(4'd10, 32'h80, 1, 0);
        axi_write(4'd11, 32'h90, 1, 9);
        axi_read(4'd12, 32'h80, 5, 2);

        // Reset in the middle of a read burst.
        @(negedge Clk);
        Arid = 4'd3; Araddr = 32'h0; Arlen = 8'd7; Arvalid = 1'b1;
        @(negedge Clk);
        Arvalid = 1'b0; Rready = 1'b1;
        repeat (2) @(negedge Clk);
        reset_pulse();

        // Reset after two of four write beats: only those two words change.
        aw_handshake(4'd13, 32'h180, 3);
        dec = 1'b0;
        for (int i = 0; i < 4; i++) begin wd_a[i] = $urandom; ws_a[i] = 4'hF; end
        w_beat(32'h180, 0, 3, dec);
        w_beat(32'h180, 1, 3, dec);
        reset_pulse();
        chk("no_bresp", 32'(Bvalid), 32'd0);
        axi_read(4'd14, 32'h180, 3, 0);

        for (int n = 0; n < 40; n++) begin
            len  = $urandom_range(0, 7);
            word = $urandom_range(0, 120);
            addr = ($urandom_range(0, 7) == 0) ? 32'h0010_0000 + 32'(4 * word) : 32'(4 * word);
            wl   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : len;
            for (int i = 0; i <= len; i++) begin wd_a[i] = $urandom; ws_a[i] = 4'($urandom_range(0, 15)); end
            axi_write(4'($urandom_range(0, 15)), addr, len, wl);
            axi_read(4'($urandom_range(0, 15)), 32'(4 * $urandom_range(0, 120)), $urandom_range(0, 7), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter MEM_AW, default 12, word-address width; the memory holds 2^MEM_AW 32-bit words.
REQ-002 Clk  in  1  single clock; all state changes on the rising edge.
REQ-003 Rest  in  1  reset, asynchronous, active-low.
REQ-004 Arid  in  4  read transaction ID.
REQ-005 Araddr  in  32  read start byte address; bits [1:0] ignored.
REQ-006 Arlen  in  8  read beats minus one.
REQ-007 Arvalid  in  1  read address valid.
REQ-008 Arready  out  1  read address accepted.
REQ-009 Rid  out  4  ID of the current read burst.
REQ-010 Rdata  out  32  read beat data.
REQ-011 Rresp  out  2  2'b00 OKAY, 2'b11 DECERR.
REQ-012 Rlast  out  1  final read beat.
REQ-013 Rvalid  out  1  read beat valid.
REQ-014 Rready  in  1  master accepts the read beat.
REQ-015 Awid  in  4  write transaction ID.
REQ-016 Awaddr  in  32  write start byte address; bits [1:0] ignored.
REQ-017 Awlen  in  8  write beats minus one.
REQ-018 Awvalid  in  1  write address valid.
REQ-019 Awready  out  1  write address accepted.
REQ-020 Wdata  in  32  write beat data.
REQ-021 Wstrb  in  4  byte-lane enables; bit n enables Wdata[8n+7:8n].
REQ-022 Wlast  in  1  master marks the final write beat.
REQ-023 Wvalid  in  1  write beat valid.
REQ-024 Wready  out  1  write beat accepted.
REQ-025 Bid  out  4  ID of the completed write.
REQ-026 Bresp  out  2  2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR.
REQ-027 Bvalid  out  1  write response valid.
REQ-028 Bready  in  1  master accepts the write response.

Function
REQ-029 Bursts are INCR with 32-bit beats only; size, burst, lock, cache and prot attributes are not ports; one outstanding read and one outstanding write.
REQ-030 Read and write paths are independent FSMs that may run concurrently.
REQ-031 Read FSM R_IDLE -> R_DATA on Arvalid&Arready, latching id, word address and remaining count = Arlen; R_DATA -> R_IDLE on Rvalid&Rready&Rlast.
REQ-032 Arready = 1 only in R_IDLE; Rvalid = 1 only in R_DATA; the first beat is valid the cycle after the AR handshake; beats are 1 per cycle while Rready = 1.
REQ-033 Rdata/Rresp/Rlast are held stable while Rvalid&!Rready; Rlast = 1 when the remaining count is 0.
REQ-034 An address is in range iff byte address [31:MEM_AW+2] == 0; in-range beats give mem[addr[MEM_AW+1:2]] with OKAY; out-of-range beats give Rdata 0 with DECERR, evaluated per beat as the address increments by 4.
REQ-035 Write FSM W_IDLE -> W_DATA on Awvalid&Awready; W_DATA -> W_RESP on the beat where the remaining count is 0; W_RESP -> W_IDLE on Bvalid&Bready.
REQ-036 Awready = 1 only in W_IDLE; Wready = 1 only in W_DATA; Bvalid = 1 only in W_RESP; Bid = latched Awid.
REQ-037 Each accepted in-range write beat updates only the strobed bytes at the current address in that clock edge; out-of-range beats are dropped.
REQ-038 Bresp priority: DECERR if any beat was out of range; else SLVERR if Wlast did not match the count-0 beat exactly; else OKAY. Burst length is always taken from Awlen, never from Wlast.
REQ-039 Same-cycle read and write of one word: the read beat returns the pre-write data.

Reset
REQ-040 While Rest = 0: both FSMs idle; Arready = Awready = 1; Rvalid = Rlast = Wready = Bvalid = 0; Rid = Bid = 0; Rdata = 0; Rresp = Bresp = 0. Memory contents are not reset.
REQ-041 Reset mid-burst abandons the burst with no response issued; partially written words keep the data already written.

Structure
REQ-042 The shared package holds the response codes (OKAY/SLVERR/DECERR) and the read/write FSM state encodings.
REQ-043 The byte-enabled single-write/single-read memory array is a sub-module named axi_sram_array; everything else is in this module.

Verification
REQ-044 Write Awaddr 0x40, Awlen 3, data 1..4, Wstrb 0xF, Wlast on beat 4 -> Bresp 00, Bid = Awid; read of the same burst returns 1,2,3,4 with Rlast on beat 4.
REQ-045 Write 0xAABBCCDD, then write 0x11223344 with Wstrb 0x5 to the same word -> read returns 0xAA22CC44.
REQ-046 Read Arlen 7 with Rready toggling every other cycle -> 8 beats, no beat lost or repeated, Rdata held while stalled.
REQ-047 Araddr 0x4000 with MEM_AW 12 -> Rresp 11 and Rdata 0 on every beat; a write to the same address -> Bresp 11 and memory unchanged.
REQ-048 Awlen 1 with Wlast asserted on beat 1 -> both beats written, Bresp 10; Rest pulsed low during a read burst -> Rvalid 0 immediately and Arready 1.
